multdiv_unit: RTL and testbench

Multi-cycle signed 32-bit multiply/divide engine in the execute stage. It consumes the bypass-selected ALU operands for `mul`/`div` instructions and returns a 32-bit result plus an exception flag. That flag feeds the XM overflow latch, which in turn redirects the destination to r30 for bypassing and writeback. `busy` stalls F/D/X while an operation is in flight.

---
 rtl/multdiv_unit_if.sv | 35 +++
 rtl/multdiv_unit.sv | 199 +++++++++++++++++++
 tb/tb_multdiv_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_unit_if.sv
// Operand/control/result bundle for multdiv_unit; master drives operands and start pulses.
// data_remainder exists only when MULTDIV_REMAINDER_EN is defined.
interface multdiv_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;
`ifdef MULTDIV_REMAINDER_EN
    logic [WIDTH-1:0] data_remainder;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy, data_remainder
    );
    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy, data_remainder
    );
`else
    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );
    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
`endif
endinterface

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes), WIDTH iterations each.
// Define MULTDIV_REMAINDER_EN to add the signed remainder output (sign follows the dividend).
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    multdiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             divZero_q, divZero_d;
    logic             divOvf_q, divOvf_d;
    logic             negQ_q, negQ_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
`ifdef MULTDIV_REMAINDER_EN
    logic             negR_q, negR_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] rem_q, rem_d;
`endif

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] absA, absB;
    logic             lastIter;

    assign absA     = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign absB     = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
    assign lastIter = (cnt_q == CW'(WIDTH - 1));

    // hi holds the Booth accumulator (one guard bit so +/-MIN_NEG cannot wrap) or the divide remainder;
    // lo holds the multiplier or the developing quotient.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        qm1_d     = qm1_q;
        opnd_d    = opnd_q;
        divZero_d = divZero_q;
        divOvf_d  = divOvf_q;
        negQ_d    = negQ_q;
        result_d  = result_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;
        busy_d    = busy_q;
`ifdef MULTDIV_REMAINDER_EN
        negR_d     = negR_q;
        dividend_d = dividend_q;
        rem_d      = rem_q;
`endif
        sum     = '0;
        shifted = '0;
        trial   = '0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (bus.ctrl_MULT) begin
                    state_d = MULT;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = bus.data_operandB;
                    qm1_d   = 1'b0;
                    opnd_d  = bus.data_operandA;
                end else if (bus.ctrl_DIV) begin
                    state_d   = DIV;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    hi_d      = '0;
                    lo_d      = absA;
                    qm1_d     = 1'b0;
                    opnd_d    = absB;
                    divZero_d = (bus.data_operandB == '0);
                    divOvf_d  = (bus.data_operandA == MIN_NEG) && (bus.data_operandB == '1);
                    negQ_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
`ifdef MULTDIV_REMAINDER_EN
                    negR_d     = bus.data_operandA[WIDTH-1];
                    dividend_d = bus.data_operandA;
`endif
                end
            end

            MULT: begin
                cnt_d = cnt_q + 1'b1;
                case ({lo_q[0], qm1_q})
                    2'b01:   sum = hi_q + {opnd_q[WIDTH-1], opnd_q};
                    2'b10:   sum = hi_q - {opnd_q[WIDTH-1], opnd_q};
                    default: sum = hi_q;
                endcase
                {hi_d, lo_d, qm1_d} = {sum[WIDTH], sum, lo_q};
                if (lastIter) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    rdy_d    = 1'b1;
                    result_d = lo_d;
                    exc_d    = (hi_d[WIDTH-1:0] != {WIDTH{lo_d[WIDTH-1]}});
`ifdef MULTDIV_REMAINDER_EN
                    rem_d    = '0;
`endif
                end
            end

            DIV: begin
                cnt_d   = cnt_q + 1'b1;
                shifted = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
                trial   = {1'b0, shifted} - {2'b00, opnd_q};
                hi_d    = trial[WIDTH+1] ? shifted : trial[WIDTH:0];
                lo_d    = {lo_q[WIDTH-2:0], ~trial[WIDTH+1]};
                if (lastIter) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    rdy_d   = 1'b1;
                    if (divZero_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else if (divOvf_q) begin
                        result_d = MIN_NEG;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = negQ_q ? -lo_d : lo_d;
                        exc_d    = 1'b0;
                    end
`ifdef MULTDIV_REMAINDER_EN
                    rem_d = divZero_q ? dividend_q
                          : (negR_q ? -hi_d[WIDTH-1:0] : hi_d[WIDTH-1:0]);
`endif
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            qm1_q     <= 1'b0;
            opnd_q    <= '0;
            divZero_q <= 1'b0;
            divOvf_q  <= 1'b0;
            negQ_q    <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
            negR_q     <= 1'b0;
            dividend_q <= '0;
            rem_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            qm1_q     <= qm1_d;
            opnd_q    <= opnd_d;
            divZero_q <= divZero_d;
            divOvf_q  <= divOvf_d;
            negQ_q    <= negQ_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
`ifdef MULTDIV_REMAINDER_EN
            negR_q     <= negR_d;
            dividend_q <= dividend_d;
            rem_q      <= rem_d;
`endif
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;
`ifdef MULTDIV_REMAINDER_EN
    assign bus.data_remainder = rem_q;
`endif
endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: expectations are queued at start and popped on data_resultRDY.
// Remainder checks are compiled in only when MULTDIV_REMAINDER_EN is defined.
module tb_multdiv_unit;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        logic [W-1:0] rem;
    } exp_t;

    localparam logic [W-1:0] MULT_A [6] = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_7FFF};
    localparam logic [W-1:0] MULT_B [6] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0001};
    localparam logic [W-1:0] DIV_A  [7] = '{32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd7, 32'd100, 32'hFFFF_FF9C};
    localparam logic [W-1:0] DIV_B  [7] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9};

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbq[$];

    multdiv_unit_if #(.WIDTH(W)) mdIf();

    multdiv_unit #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (mdIf)
    );

    always #5 clock = ~clock;

    function automatic exp_t mkExp(input logic [W-1:0] res, input logic exc, input logic [W-1:0] rem);
        exp_t e;
        e.res = res;
        e.exc = exc;
        e.rem = rem;
        return e;
    endfunction

    // Reference behaviour from native 64-bit and signed 32-bit arithmetic.
    function automatic exp_t model(input bit isMult, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint p;
        int     sa, sb, q, r;
        e = mkExp('0, 1'b0, '0);
        if (isMult) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            e.res = p[31:0];
            e.exc = (p != longint'($signed(p[31:0])));
        end else if (b == 0) begin
            e = mkExp(32'd0, 1'b1, a);
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e = mkExp(32'h8000_0000, 1'b1, 32'd0);
        end else begin
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
            e  = mkExp(q, 1'b0, r);
        end
        return e;
    endfunction

    // Drive a start pulse at the current negedge; returns at the negedge after the start edge.
    task automatic applyStimulus(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
        mdIf.ctrl_MULT     = m;
        mdIf.ctrl_DIV      = d;
        mdIf.data_operandA = a;
        mdIf.data_operandB = b;
        @(negedge clock);
        mdIf.ctrl_MULT     = 1'b0;
        mdIf.ctrl_DIV      = 1'b0;
        mdIf.data_operandA = $urandom;
        mdIf.data_operandB = $urandom;
    endtask

    task automatic waitRdy(output int lat, output int busyCycles);
        lat = 0;
        busyCycles = 0;
        while (lat < 100 && mdIf.data_resultRDY !== 1'b1) begin
            if (mdIf.busy === 1'b1) busyCycles++;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if (mdIf.data_result !== 32'd0) begin miscompares++; $display("[TB] FAIL reset result: got %h expected 0", mdIf.data_result); end
        vectors++;
        if (mdIf.data_exception !== 1'b0) begin miscompares++; $display("[TB] FAIL reset exception: got %b expected 0", mdIf.data_exception); end
        vectors++;
        if (mdIf.data_resultRDY !== 1'b0) begin miscompares++; $display("[TB] FAIL reset rdy: got %b expected 0", mdIf.data_resultRDY); end
        vectors++;
        if (mdIf.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset busy: got %b expected 0", mdIf.busy); end
`ifdef MULTDIV_REMAINDER_EN
        vectors++;
        if (mdIf.data_remainder !== 32'd0) begin miscompares++; $display("[TB] FAIL reset remainder: got %h expected 0", mdIf.data_remainder); end
`endif
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_mult();
        exp_t e;
        int   lat, bc;
        for (int i = 0; i < 6; i++) begin
            if (i == 0)      sbq.push_back(mkExp(32'hFFFF_FFEB, 1'b0, 32'd0));
            else if (i == 1) sbq.push_back(mkExp(32'h0000_0000, 1'b1, 32'd0));
            else             sbq.push_back(model(1'b1, MULT_A[i], MULT_B[i]));
            applyStimulus(1'b1, 1'b0, MULT_A[i], MULT_B[i]);
            waitRdy(lat, bc);
            vectors++;
            if (lat != 32) begin miscompares++; $display("[TB] FAIL mult[%0d] latency: got %0d expected 32", i, lat); end
            vectors++;
            if (bc != 32) begin miscompares++; $display("[TB] FAIL mult[%0d] busy cycles: got %0d expected 32", i, bc); end
            e = sbq.pop_front();
            vectors++;
            if (mdIf.data_result !== e.res) begin miscompares++; $display("[TB] FAIL mult[%0d] result: got %h expected %h", i, mdIf.data_result, e.res); end
            vectors++;
            if (mdIf.data_exception !== e.exc) begin miscompares++; $display("[TB] FAIL mult[%0d] exception: got %b expected %b", i, mdIf.data_exception, e.exc); end
`ifdef MULTDIV_REMAINDER_EN
            vectors++;
            if (mdIf.data_remainder !== e.rem) begin miscompares++; $display("[TB] FAIL mult[%0d] remainder: got %h expected %h", i, mdIf.data_remainder, e.rem); end
`endif
            @(negedge clock);
            vectors++;
            if (mdIf.data_resultRDY !== 1'b0) begin miscompares++; $display("[TB] FAIL mult[%0d] rdy width: got %b expected 0", i, mdIf.data_resultRDY); end
            vectors++;
            if (mdIf.data_result !== e.res) begin miscompares++; $display("[TB] FAIL mult[%0d] result hold: got %h expected %h", i, mdIf.data_result, e.res); end
        end
    endtask

    task automatic test_div();
        exp_t e;
        int   lat, bc;
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      sbq.push_back(mkExp(32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF));
            else if (i == 1) sbq.push_back(mkExp(32'h0000_0000, 1'b1, 32'd5));
            else if (i == 2) sbq.push_back(mkExp(32'h8000_0000, 1'b1, 32'd0));
            else             sbq.push_back(model(1'b0, DIV_A[i], DIV_B[i]));
            applyStimulus(1'b0, 1'b1, DIV_A[i], DIV_B[i]);
            waitRdy(lat, bc);
            vectors++;
            if (lat != 32) begin miscompares++; $display("[TB] FAIL div[%0d] latency: got %0d expected 32", i, lat); end
            e = sbq.pop_front();
            vectors++;
            if (mdIf.data_result !== e.res) begin miscompares++; $display("[TB] FAIL div[%0d] quotient: got %h expected %h", i, mdIf.data_result, e.res); end
            vectors++;
            if (mdIf.data_exception !== e.exc) begin miscompares++; $display("[TB] FAIL div[%0d] exception: got %b expected %b", i, mdIf.data_exception, e.exc); end
`ifdef MULTDIV_REMAINDER_EN
            vectors++;
            if (mdIf.data_remainder !== e.rem) begin miscompares++; $display("[TB] FAIL div[%0d] remainder: got %h expected %h", i, mdIf.data_remainder, e.rem); end
`endif
            @(negedge clock);
        end
    endtask

    task automatic test_ignore_busy();
        exp_t e;
        int   lat, bc, extra;
        sbq.push_back(mkExp(32'd42, 1'b0, 32'd0));
        applyStimulus(1'b1, 1'b0, 32'd6, 32'd7);
        repeat (9) @(negedge clock);
        applyStimulus(1'b0, 1'b1, 32'd9, 32'd3);
        waitRdy(lat, bc);
        vectors++;
        if (lat + 10 != 32) begin miscompares++; $display("[TB] FAIL ignore latency: got %0d expected 32", lat + 10); end
        e = sbq.pop_front();
        vectors++;
        if (mdIf.data_result !== e.res) begin miscompares++; $display("[TB] FAIL ignore result: got %h expected %h", mdIf.data_result, e.res); end
        vectors++;
        if (mdIf.data_exception !== e.exc) begin miscompares++; $display("[TB] FAIL ignore exception: got %b expected %b", mdIf.data_exception, e.exc); end
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (mdIf.data_resultRDY === 1'b1) extra++;
        end
        vectors++;
        if (extra != 0) begin miscompares++; $display("[TB] FAIL ignore extra rdy: got %0d expected 0", extra); end

        sbq.push_back(model(1'b1, 32'hFFFF_FFFB, 32'd3));
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd3);
        waitRdy(lat, bc);
        e = sbq.pop_front();
        vectors++;
        if (mdIf.data_result !== e.res) begin miscompares++; $display("[TB] FAIL mult-wins result: got %h expected %h", mdIf.data_result, e.res); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat, bc;
        sbq.push_back(model(1'b1, 32'd123, 32'hFFFF_FFFC));
        applyStimulus(1'b1, 1'b0, 32'd123, 32'hFFFF_FFFC);
        waitRdy(lat, bc);
        e = sbq.pop_front();
        vectors++;
        if (mdIf.data_result !== e.res) begin miscompares++; $display("[TB] FAIL b2b first result: got %h expected %h", mdIf.data_result, e.res); end
        sbq.push_back(model(1'b0, 32'd100, 32'hFFFF_FFF9));
        applyStimulus(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
        vectors++;
        if (mdIf.data_resultRDY !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b rdy after restart: got %b expected 0", mdIf.data_resultRDY); end
        vectors++;
        if (mdIf.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b busy after restart: got %b expected 1", mdIf.busy); end
        waitRdy(lat, bc);
        vectors++;
        if (lat != 32) begin miscompares++; $display("[TB] FAIL b2b second latency: got %0d expected 32", lat); end
        e = sbq.pop_front();
        vectors++;
        if (mdIf.data_result !== e.res) begin miscompares++; $display("[TB] FAIL b2b second result: got %h expected %h", mdIf.data_result, e.res); end
`ifdef MULTDIV_REMAINDER_EN
        vectors++;
        if (mdIf.data_remainder !== e.rem) begin miscompares++; $display("[TB] FAIL b2b second remainder: got %h expected %h", mdIf.data_remainder, e.rem); end
`endif
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat, bc, seen;
        sbq.push_back(model(1'b1, 32'h0000_1234, 32'h0000_5678));
        applyStimulus(1'b1, 1'b0, 32'h0000_1234, 32'h0000_5678);
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (mdIf.data_result !== 32'd0) begin miscompares++; $display("[TB] FAIL midreset result: got %h expected 0", mdIf.data_result); end
        vectors++;
        if (mdIf.data_exception !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset exception: got %b expected 0", mdIf.data_exception); end
        vectors++;
        if (mdIf.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset busy: got %b expected 0", mdIf.busy); end
        vectors++;
        if (mdIf.data_resultRDY !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset rdy: got %b expected 0", mdIf.data_resultRDY); end
        sbq.delete();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (mdIf.data_resultRDY === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin miscompares++; $display("[TB] FAIL midreset stray rdy: got %0d expected 0", seen); end

        sbq.push_back(mkExp(32'd144, 1'b0, 32'd0));
        applyStimulus(1'b1, 1'b0, 32'd12, 32'd12);
        waitRdy(lat, bc);
        vectors++;
        if (lat != 32) begin miscompares++; $display("[TB] FAIL post-reset latency: got %0d expected 32", lat); end
        e = sbq.pop_front();
        vectors++;
        if (mdIf.data_result !== e.res) begin miscompares++; $display("[TB] FAIL post-reset result: got %h expected %h", mdIf.data_result, e.res); end
        vectors++;
        if (mdIf.data_exception !== e.exc) begin miscompares++; $display("[TB] FAIL post-reset exception: got %b expected %b", mdIf.data_exception, e.exc); end
        @(negedge clock);
    endtask

    initial begin
        mdIf.ctrl_MULT     = 1'b0;
        mdIf.ctrl_DIV      = 1'b0;
        mdIf.data_operandA = '0;
        mdIf.data_operandB = '0;
        test_reset();
        test_mult();
        test_div();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
